// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU function units (rotate, mul, div):
// operand widths and the common IDLE/ROT/DONE state encoding.
package alu_pkg;

  localparam int WORD_W = 32;
  localparam int SH_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Rotate amount is taken modulo WORD_W, so only the low SH_W bits of B matter.
  function automatic logic [SH_W-1:0] sh_amount(input logic [WORD_W-1:0] b);
    return b[SH_W-1:0];
  endfunction

endpackage

// File: rtl/ror_step.sv
// Combinational rotate-right by one bit; with ROR_FASTSTEP_EN defined it can
// also rotate by four bits when by4 is set.
module ror_step
  import alu_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] din,
`ifdef ROR_FASTSTEP_EN
  input  logic         by4,
`endif
  output logic [W-1:0] dout
);

`ifdef ROR_FASTSTEP_EN
  assign dout = by4 ? {din[3:0], din[W-1:4]} : {din[0], din[W-1:1]};
`else
  assign dout = {din[0], din[W-1:1]};
`endif

endmodule

// File: rtl/ror_iter.sv
// Multi-cycle rotate-right unit with start/busy/done handshake and zero-extended
// 64-bit Z bus. Define ROR_FASTSTEP_EN to rotate four bits per cycle when possible.
module ror_iter #(
  parameter int WORD_W = alu_pkg::WORD_W,
  parameter int SH_W   = alu_pkg::SH_W
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [WORD_W-1:0]   A,
  input  logic [WORD_W-1:0]   B,
  output logic                busy,
  output logic                done,
  output logic [2*WORD_W-1:0] Z
);

  import alu_pkg::*;

  alu_state_e        state_r;
  logic [WORD_W-1:0] r_r;
  logic [SH_W-1:0]   count_r;
  logic              busy_r;
  logic              done_r;

  logic [WORD_W-1:0] step_s;
  logic [SH_W-1:0]   sh_s;
  logic [SH_W-1:0]   dec_s;

  assign sh_s = sh_amount(B);

`ifdef ROR_FASTSTEP_EN
  logic by4_s;
  assign by4_s = (count_r >= SH_W'(4));
  assign dec_s = by4_s ? SH_W'(4) : SH_W'(1);

  ror_step #(.W(WORD_W)) u_step (
    .din  (r_r),
    .by4  (by4_s),
    .dout (step_s)
  );
`else
  assign dec_s = SH_W'(1);

  ror_step #(.W(WORD_W)) u_step (
    .din  (r_r),
    .dout (step_s)
  );
`endif

  // Handshake FSM, rotate register and remaining-step counter.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r <= ST_IDLE;
      r_r     <= {WORD_W{1'b0}};
      count_r <= {SH_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            r_r     <= A;
            count_r <= sh_s;
            busy_r  <= 1'b1;
            if (sh_s != {SH_W{1'b0}}) begin
              state_r <= ST_ROT;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_ROT: begin
          r_r     <= step_s;
          count_r <= count_r - dec_s;
          busy_r  <= 1'b1;
          // The last step lands exactly on zero; done rises with the final value.
          if (count_r == dec_s) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= {SH_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign Z    = {{WORD_W{1'b0}}, r_r};

endmodule

// File: tb/tb_ror_iter.sv
// Randomized self-checking bench for ror_iter against a behavioural rotate model.
module tb_ror_iter;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] Z;

  int checks;
  int errors;

  ror_iter dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ror(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = int'(b % 32);
    if (s == 0) return a;
    return (a >> s) | (a << (32 - s));
  endfunction

  function automatic int exp_lat(input logic [31:0] b);
    int s;
    s = int'(b % 32);
`ifdef ROR_FASTSTEP_EN
    return s / 4 + s % 4 + 1;
`else
    return s + 1;
`endif
  endfunction

  // inj: cycle in which a stray start is raised; clr: cycle in which clear aborts.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int clr);
    logic [63:0] expz;
    int  lat;
    bit  got;
    bit  aborted;
    int  late_done;
    expz = {32'h0, ref_ror(a, b)};
    lat  = exp_lat(b);
    got = 1'b0;
    aborted = 1'b0;
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    for (int c = 1; c <= 40 && !got && !aborted; c++) begin
      @(negedge clock);
      if (c == clr) begin
        #2 clear = 1'b0;
        #1;
        check("abort_busy", {63'h0, busy}, 64'h0);
        check("abort_done", {63'h0, done}, 64'h0);
        check("abort_z", Z, 64'h0);
        clear = 1'b1;
        aborted = 1'b1;
      end else if (done) begin
        got = 1'b1;
        check("latency", 64'(c), 64'(lat));
        check("z_result", Z, expz);
        check("busy_in_done", {63'h0, busy}, 64'h1);
      end else begin
        check("busy_run", {63'h0, busy}, 64'h1);
      end
      if (c == inj) begin
        start = 1'b1;
        A = $urandom;
        B = $urandom;
      end else if (c == inj + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (aborted) begin
      late_done = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clock);
        if (done) late_done++;
      end
      check("no_done_after_abort", 64'(late_done), 64'h0);
    end else if (!got) begin
      check("done_timeout", 64'h0, 64'h1);
    end else begin
      @(negedge clock);
      check("idle_done", {63'h0, done}, 64'h0);
      check("idle_busy", {63'h0, busy}, 64'h0);
      check("z_hold", Z, expz);
    end
  endtask

  initial begin
    int  c1, c2;
    bit  seen1, seen2;
    checks = 0;
    errors = 0;
    clear = 1'b0;
    start = 1'b0;
    A = 32'h0;
    B = 32'h0;
    #12;
    check("reset_busy", {63'h0, busy}, 64'h0);
    check("reset_done", {63'h0, done}, 64'h0);
    check("reset_z", Z, 64'h0);
    @(negedge clock);
    clear = 1'b1;
    repeat (2) @(negedge clock);

    run_op(32'h00000001, 32'd1, 0, 0);
    check("tp1_z", Z, 64'h00000000_80000000);
    run_op(32'h12345678, 32'd4, 0, 0);
    check("tp2_z", Z, 64'h00000000_81234567);
    run_op(32'hDEADBEEF, 32'd0, 0, 0);
    check("tp3_z", Z, 64'h00000000_DEADBEEF);
    run_op(32'hDEADBEEF, 32'd32, 0, 0);
    check("tp4_z", Z, 64'h00000000_DEADBEEF);
    run_op(32'h80000001, 32'd37, 0, 0);
    check("tp5_z", Z, 64'h00000000_0C000000);
    run_op(32'h00000000, 32'd31, 0, 0);
    run_op(32'hFFFFFFFF, 32'd31, 0, 0);
    run_op(32'hA5A5_0F0F, 32'd10, 3, 0);
    run_op(32'hCAFE_F00D, 32'd20, 0, 7);
    run_op(32'h0000_8001, 32'd7, 0, 0);

    // start held high: the next operation begins right after the idle cycle.
    @(negedge clock);
    A = 32'h1357_9BDF;
    B = 32'd3;
    start = 1'b1;
    seen1 = 1'b0;
    seen2 = 1'b0;
    c1 = 0;
    c2 = 0;
    for (int c = 1; c <= 60 && !seen2; c++) begin
      @(negedge clock);
      if (done && !seen1) begin
        seen1 = 1'b1;
        c1 = c;
      end else if (done && seen1) begin
        seen2 = 1'b1;
        c2 = c;
        start = 1'b0;
        check("b2b_z", Z, {32'h0, ref_ror(32'h1357_9BDF, 32'd3)});
      end
    end
    start = 1'b0;
    check("b2b_seen", {62'h0, seen1, seen2}, 64'h3);
    check("b2b_gap", 64'(c2 - c1), 64'(exp_lat(32'd3) + 1));
    repeat (3) @(negedge clock);

    for (int i = 0; i < 30; i++) begin
      run_op($urandom, $urandom, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
